// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared constants for the UART command/framing path.
// Holds the command bytes, the 2-bit frame state encodings, the error codes
// and the default UART bit period shared with the byte receiver.
package uart_cmd_ctrl_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 10417;

  localparam logic [7:0] CMD_KEY  = 8'h4B;  // 'K'
  localparam logic [7:0] CMD_DATA = 8'h44;  // 'D'

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RX_KEY   = 2'd1;
  localparam logic [1:0] ST_RX_BLK   = 2'd2;
  localparam logic [1:0] ST_HOLD_BLK = 2'd3;

  localparam logic [1:0] ERR_UNKNOWN_CMD = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT     = 2'd2;
  localparam logic [1:0] ERR_OVERRUN     = 2'd3;

  // Byte count value seen when the last payload byte arrives.
  localparam logic [4:0] KEY_LAST_IDX = 5'd31;
  localparam logic [4:0] BLK_LAST_IDX = 5'd15;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bundle of the receiver-side byte stream and the AES-core-side outputs.
//   slave  : the command controller (consumes bytes, drives key/block/status)
//   master : the surrounding environment (receiver + AES core)
interface uart_cmd_ctrl_if;
  logic         rx_dv_i;      // byte valid pulse from the UART receiver
  logic [7:0]   rx_byte_i;    // received byte
  logic [255:0] key_o;        // last complete key, first byte in [255:248]
  logic         key_valid_o;  // one-cycle pulse when key_o updates
  logic [127:0] blk_o;        // last complete block, first byte in [127:120]
  logic         blk_valid_o;  // block available, held until accepted
  logic         blk_ready_i;  // AES core accepts the block
  logic         busy_o;       // controller not idle
  logic         err_o;        // one-cycle error pulse
  logic [1:0]   err_code_o;   // cause of the last error

  modport slave (
    input  rx_dv_i, rx_byte_i, blk_ready_i,
    output key_o, key_valid_o, blk_o, blk_valid_o, busy_o, err_o, err_code_o
  );

  modport master (
    output rx_dv_i, rx_byte_i, blk_ready_i,
    input  key_o, key_valid_o, blk_o, blk_valid_o, busy_o, err_o, err_code_o
  );
endinterface

// File: rtl/uart_cmd_ctrl_rx_timeout_timer.sv
// Inter-byte timeout timer.
//   clk_i, rst_i : clock and synchronous active-high reset
//   enable       : count while high; counter held at zero otherwise
//   reload       : restart the idle interval (a byte arrived)
//   expired      : combinational pulse in the cycle the counter sits at
//                  TIMEOUT_CLKS-1 with no reload
module rx_timeout_timer #(
  parameter int unsigned TIMEOUT_CLKS = 312510
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable,
  input  logic reload,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = enable && !reload && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!enable || reload || expired) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command/framing controller between the UART byte receiver and the AES-256
// core. Decodes a one-byte command, assembles a 32-byte key or 16-byte block,
// pulses key_valid_o for keys, holds blocks under a valid/ready handshake and
// flags unknown commands, inter-byte timeouts and overruns.
//   clk_i, rst_i : clock and synchronous active-high reset
//   bus          : byte stream in, key/block/status out (slave modport)
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned TIMEOUT_CLKS = 30 * CLKS_PER_BIT
) (
  input  logic           clk_i,
  input  logic           rst_i,
  uart_cmd_ctrl_if.slave bus
);

  logic [1:0]   state_q, state_d;
  logic [4:0]   byte_cnt_q, byte_cnt_d;
  logic [255:0] sr_q, sr_d, sr_shift;
  logic [255:0] key_q, key_d;
  logic [127:0] blk_q, blk_d;
  logic         key_valid_q, key_valid_d;
  logic         blk_valid_q, blk_valid_d;
  logic         err_q, err_d;
  logic [1:0]   err_code_q, err_code_d;
  logic         rx_active, reload, expired, decode;

  assign rx_active = (state_q == ST_RX_KEY) || (state_q == ST_RX_BLK);
  assign reload    = rx_active && bus.rx_dv_i;

  rx_timeout_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .enable  (rx_active),
    .reload  (reload),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    sr_d        = sr_q;
    key_d       = key_q;
    blk_d       = blk_q;
    key_valid_d = 1'b0;
    blk_valid_d = blk_valid_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    decode      = 1'b0;
    sr_shift    = {sr_q[247:0], bus.rx_byte_i};

    case (state_q)
      ST_IDLE: decode = bus.rx_dv_i;
      ST_RX_KEY, ST_RX_BLK: begin
        // A byte in the expiry cycle wins over the timeout.
        if (bus.rx_dv_i) begin
          sr_d       = sr_shift;
          byte_cnt_d = byte_cnt_q + 5'd1;
          if (state_q == ST_RX_KEY && byte_cnt_q == KEY_LAST_IDX) begin
            key_d       = sr_shift;
            key_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end else if (state_q == ST_RX_BLK && byte_cnt_q == BLK_LAST_IDX) begin
            blk_d       = sr_shift[127:0];
            blk_valid_d = 1'b1;
            state_d     = ST_HOLD_BLK;
          end
        end else if (expired) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      ST_HOLD_BLK: begin
        if (bus.blk_ready_i) begin
          // Handshake completes; a byte arriving now is a new command.
          blk_valid_d = 1'b0;
          state_d     = ST_IDLE;
          decode      = bus.rx_dv_i;
        end else if (bus.rx_dv_i) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (decode) begin
      byte_cnt_d = '0;
      sr_d       = '0;
      if (bus.rx_byte_i == CMD_KEY) begin
        state_d = ST_RX_KEY;
      end else if (bus.rx_byte_i == CMD_DATA) begin
        state_d = ST_RX_BLK;
      end else begin
        state_d    = ST_IDLE;
        err_d      = 1'b1;
        err_code_d = ERR_UNKNOWN_CMD;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      sr_q        <= '0;
      key_q       <= '0;
      blk_q       <= '0;
      key_valid_q <= 1'b0;
      blk_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      sr_q        <= sr_d;
      key_q       <= key_d;
      blk_q       <= blk_d;
      key_valid_q <= key_valid_d;
      blk_valid_q <= blk_valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.key_o       = key_q;
  assign bus.key_valid_o = key_valid_q;
  assign bus.blk_o       = blk_q;
  assign bus.blk_valid_o = blk_valid_q;
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.err_o       = err_q;
  assign bus.err_code_o  = err_code_q;

endmodule
